axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder (slave end) exposing a bank of NREGS read/write registers. Connects to the `slaver` side of `axi_lite_inf`, with flattened ports. A master BFM or CPU drives it. Register contents are exported flat to user logic, with a per-register write strobe. Write and read channels run independently; AW and W are accepted in any order.

---
 rtl/axi_lite_reg_slave.sv | 151 +++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank responder: NREGS registers exported flat, with a per-register write pulse.
// Optional `AXI_LITE_REG_DECERR_EN` makes out-of-range accesses answer DECERR instead of OKAY.
module axi_lite_reg_slave #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREGS = 16
) (
  input  logic                   axi_lite_aclk,
  input  logic                   axi_lite_resetn,
  input  logic                   axi_lite_awvalid,
  output logic                   axi_lite_awready,
  input  logic [ASIZE-1:0]       axi_lite_awaddr,
  input  logic                   axi_lite_wvalid,
  output logic                   axi_lite_wready,
  input  logic [DSIZE-1:0]       axi_lite_wdata,
  output logic                   axi_lite_bvalid,
  input  logic                   axi_lite_bready,
  output logic [1:0]             axi_lite_bresp,
  input  logic                   axi_lite_arvalid,
  output logic                   axi_lite_arready,
  input  logic [ASIZE-1:0]       axi_lite_araddr,
  output logic                   axi_lite_rvalid,
  input  logic                   axi_lite_rready,
  output logic [DSIZE-1:0]       axi_lite_rdata,
  output logic [1:0]             axi_lite_rresp,
  output logic [NREGS*DSIZE-1:0] reg_q,
  output logic [NREGS-1:0]       reg_wr_pulse
);

  localparam int LANE_BITS = $clog2(DSIZE / 8);
  localparam int IDX_BITS  = $clog2(NREGS);
  localparam int HI_BITS   = LANE_BITS + IDX_BITS;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REG_DECERR_EN
  localparam logic [1:0] RESP_OOR = 2'b11;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic                 rdy_en;
  logic                 aw_held;
  logic                 w_held;
  logic [ASIZE-1:0]     aw_addr_q;
  logic [DSIZE-1:0]     w_data_q;
  logic [DSIZE-1:0]     regs [NREGS];
  rstate_t              rstate;

  logic                 aw_fire;
  logic                 w_fire;
  logic                 ar_fire;
  logic                 commit;
  logic [ASIZE-1:0]     wr_addr;
  logic [DSIZE-1:0]     wr_data;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [IDX_BITS-1:0]  rd_idx;
  logic                 wr_in_range;
  logic                 rd_in_range;

  function automatic logic addr_in_range(input logic [ASIZE-1:0] a);
    return (a >> HI_BITS) == '0;
  endfunction

  assign axi_lite_awready = rdy_en & ~aw_held & ~axi_lite_bvalid;
  assign axi_lite_wready  = rdy_en & ~w_held & ~axi_lite_bvalid;
  assign axi_lite_arready = rdy_en & (rstate == R_IDLE);

  assign aw_fire = axi_lite_awvalid & axi_lite_awready;
  assign w_fire  = axi_lite_wvalid & axi_lite_wready;
  assign ar_fire = axi_lite_arvalid & axi_lite_arready;

  // A write commits on the edge where both halves are available, held or arriving now.
  assign commit  = (aw_held | aw_fire) & (w_held | w_fire);
  assign wr_addr = aw_held ? aw_addr_q : axi_lite_awaddr;
  assign wr_data = w_held ? w_data_q : axi_lite_wdata;
  assign wr_idx  = wr_addr[LANE_BITS +: IDX_BITS];
  assign rd_idx  = axi_lite_araddr[LANE_BITS +: IDX_BITS];
  assign wr_in_range = addr_in_range(wr_addr);
  assign rd_in_range = addr_in_range(axi_lite_araddr);

  for (genvar i = 0; i < NREGS; i++) begin : g_export
    assign reg_q[i*DSIZE +: DSIZE] = regs[i];
  end

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      rdy_en          <= 1'b0;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      axi_lite_bvalid <= 1'b0;
      axi_lite_bresp  <= RESP_OKAY;
      reg_wr_pulse    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      rdy_en       <= 1'b1;
      reg_wr_pulse <= '0;
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi_lite_awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= axi_lite_wdata;
      end
      if (axi_lite_bvalid && axi_lite_bready) axi_lite_bvalid <= 1'b0;
      if (commit) begin
        aw_held         <= 1'b0;
        w_held          <= 1'b0;
        axi_lite_bvalid <= 1'b1;
        axi_lite_bresp  <= wr_in_range ? RESP_OKAY : RESP_OOR;
        if (wr_in_range) begin
          regs[wr_idx]         <= wr_data;
          reg_wr_pulse[wr_idx] <= 1'b1;
        end
      end
    end
  end

  // Read data is sampled from the bank before any same-edge write lands, so it sees the old value.
  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      rstate          <= R_IDLE;
      axi_lite_rvalid <= 1'b0;
      axi_lite_rdata  <= '0;
      axi_lite_rresp  <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_fire) begin
            rstate          <= R_DATA;
            axi_lite_rvalid <= 1'b1;
            axi_lite_rdata  <= rd_in_range ? regs[rd_idx] : '0;
            axi_lite_rresp  <= rd_in_range ? RESP_OKAY : RESP_OOR;
          end
        end
        R_DATA: begin
          if (axi_lite_rready) begin
            rstate          <= R_IDLE;
            axi_lite_rvalid <= 1'b0;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave (ASIZE=32, DSIZE=32, NREGS=16).
module tb_axi_lite_reg_slave;

  logic          clk;
  logic          resetn;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [1:0]    bresp, rresp;
  logic [511:0]  reg_q;
  logic [15:0]   reg_wr_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_regs [16];

`ifdef AXI_LITE_REG_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  axi_lite_reg_slave #(.ASIZE(32), .DSIZE(32), .NREGS(16)) dut (
    .axi_lite_aclk    (clk),
    .axi_lite_resetn  (resetn),
    .axi_lite_awvalid (awvalid),
    .axi_lite_awready (awready),
    .axi_lite_awaddr  (awaddr),
    .axi_lite_wvalid  (wvalid),
    .axi_lite_wready  (wready),
    .axi_lite_wdata   (wdata),
    .axi_lite_bvalid  (bvalid),
    .axi_lite_bready  (bready),
    .axi_lite_bresp   (bresp),
    .axi_lite_arvalid (arvalid),
    .axi_lite_arready (arready),
    .axi_lite_araddr  (araddr),
    .axi_lite_rvalid  (rvalid),
    .axi_lite_rready  (rready),
    .axi_lite_rdata   (rdata),
    .axi_lite_rresp   (rresp),
    .reg_q            (reg_q),
    .reg_wr_pulse     (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] expected_q();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the chosen valids for one clock edge, then drop them.
  task automatic applyStimulus(input bit do_aw, input bit do_w, input bit do_ar,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] ra);
    awvalid = do_aw;
    wvalid  = do_w;
    arvalid = do_ar;
    awaddr  = a;
    wdata   = d;
    araddr  = ra;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_awready"}, 512'(awready), 512'(0));
    checkOutput({tag, "_wready"},  512'(wready),  512'(0));
    checkOutput({tag, "_arready"}, 512'(arready), 512'(0));
    checkOutput({tag, "_bvalid"},  512'(bvalid),  512'(0));
    checkOutput({tag, "_rvalid"},  512'(rvalid),  512'(0));
    checkOutput({tag, "_bresp"},   512'(bresp),   512'(0));
    checkOutput({tag, "_rresp"},   512'(rresp),   512'(0));
    checkOutput({tag, "_rdata"},   512'(rdata),   512'(0));
    checkOutput({tag, "_reg_q"},   reg_q,         512'(0));
    checkOutput({tag, "_pulse"},   512'(reg_wr_pulse), 512'(0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0;

    $display("[TB] reset");
    tick(); tick();
    check_reset_state("rst");
    resetn = 1'b1;
    checkOutput("rst_rel_awready_low", 512'(awready), 512'(0));
    tick();
    checkOutput("rst_rel_awready", 512'(awready), 512'(1));
    checkOutput("rst_rel_wready",  512'(wready),  512'(1));
    checkOutput("rst_rel_arready", 512'(arready), 512'(1));

    $display("[TB] AW before W");
    applyStimulus(1, 0, 0, 32'h8, 32'h0, 32'h0);
    checkOutput("t1_awready_held", 512'(awready), 512'(0));
    checkOutput("t1_wready",       512'(wready),  512'(1));
    checkOutput("t1_bvalid_early", 512'(bvalid),  512'(0));
    tick(); tick();
    applyStimulus(0, 1, 0, 32'h0, 32'hDEADBEEF, 32'h0);
    exp_regs[2] = 32'hDEADBEEF;
    checkOutput("t1_bvalid", 512'(bvalid), 512'(1));
    checkOutput("t1_bresp",  512'(bresp),  512'(0));
    checkOutput("t1_reg_q",  reg_q, expected_q());
    checkOutput("t1_pulse",  512'(reg_wr_pulse), 512'(16'h0004));
    tick();
    checkOutput("t1_bvalid_done", 512'(bvalid), 512'(0));
    checkOutput("t1_pulse_done",  512'(reg_wr_pulse), 512'(0));
    checkOutput("t1_awready_back", 512'(awready), 512'(1));

    $display("[TB] W before AW, then read back");
    applyStimulus(0, 1, 0, 32'h0, 32'h12345678, 32'h0);
    checkOutput("t2_wready_held", 512'(wready),  512'(0));
    checkOutput("t2_awready",     512'(awready), 512'(1));
    checkOutput("t2_bvalid_early", 512'(bvalid), 512'(0));
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'h0);
    exp_regs[0] = 32'h12345678;
    checkOutput("t2_bvalid", 512'(bvalid), 512'(1));
    checkOutput("t2_reg_q",  reg_q, expected_q());
    checkOutput("t2_pulse",  512'(reg_wr_pulse), 512'(16'h0001));
    tick();
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h0);
    checkOutput("t2_rvalid",  512'(rvalid),  512'(1));
    checkOutput("t2_rdata",   512'(rdata),   512'(32'h12345678));
    checkOutput("t2_rresp",   512'(rresp),   512'(0));
    checkOutput("t2_arready", 512'(arready), 512'(0));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput("t2_rvalid_done", 512'(rvalid),  512'(0));
    checkOutput("t2_arready_back", 512'(arready), 512'(1));

    $display("[TB] B back-pressure");
    bready = 1'b0;
    applyStimulus(1, 1, 0, 32'h4, 32'hA5A5A5A5, 32'h0);
    exp_regs[1] = 32'hA5A5A5A5;
    checkOutput("t3_reg_q", reg_q, expected_q());
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_bvalid_hold",  512'(bvalid),  512'(1));
      checkOutput("t3_bresp_hold",   512'(bresp),   512'(0));
      checkOutput("t3_awready_hold", 512'(awready), 512'(0));
      checkOutput("t3_wready_hold",  512'(wready),  512'(0));
      checkOutput("t3_pulse_once",   512'(reg_wr_pulse), i == 0 ? 512'(16'h0002) : 512'(0));
      tick();
    end
    bready = 1'b1;
    tick();
    checkOutput("t3_bvalid_done", 512'(bvalid),  512'(0));
    checkOutput("t3_awready",     512'(awready), 512'(1));
    checkOutput("t3_wready",      512'(wready),  512'(1));

    $display("[TB] out-of-range access");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h40);
    checkOutput("t4_rvalid", 512'(rvalid), 512'(1));
    checkOutput("t4_rdata",  512'(rdata),  512'(0));
    checkOutput("t4_rresp",  512'(rresp),  512'(OOR_RESP));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    applyStimulus(1, 1, 0, 32'h40, 32'hFFFFFFFF, 32'h0);
    checkOutput("t4_bvalid", 512'(bvalid), 512'(1));
    checkOutput("t4_bresp",  512'(bresp),  512'(OOR_RESP));
    checkOutput("t4_reg_q",  reg_q, expected_q());
    checkOutput("t4_pulse",  512'(reg_wr_pulse), 512'(0));
    tick();

    $display("[TB] same-edge read and write");
    applyStimulus(1, 1, 0, 32'h4, 32'h1, 32'h0);
    exp_regs[1] = 32'h1;
    tick();
    applyStimulus(1, 1, 1, 32'h4, 32'h2, 32'h4);
    exp_regs[1] = 32'h2;
    checkOutput("t5_rdata_old", 512'(rdata), 512'(32'h1));
    checkOutput("t5_reg_q",     reg_q, expected_q());
    checkOutput("t5_bvalid",    512'(bvalid), 512'(1));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h4);
    checkOutput("t5_rdata_new", 512'(rdata), 512'(32'h2));
    rready = 1'b1;
    tick();
    rready = 1'b0;

    $display("[TB] reset with B and R outstanding");
    bready = 1'b0;
    applyStimulus(1, 1, 0, 32'hC, 32'h11, 32'h0);
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h0);
    checkOutput("t6_bvalid_pre", 512'(bvalid), 512'(1));
    checkOutput("t6_rvalid_pre", 512'(rvalid), 512'(1));
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    check_reset_state("t6_async");
    tick();
    resetn = 1'b1;
    bready = 1'b1;
    checkOutput("t6_arready_low", 512'(arready), 512'(0));
    tick();
    checkOutput("t6_awready", 512'(awready), 512'(1));
    checkOutput("t6_arready", 512'(arready), 512'(1));

    $display("[TB] reset with AW held");
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 32'h0);
    checkOutput("t7_aw_held", 512'(awready), 512'(0));
    resetn = 1'b0;
    #1;
    check_reset_state("t7_async");
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("t7_awready", 512'(awready), 512'(1));
    applyStimulus(0, 1, 0, 32'h0, 32'h77, 32'h0);
    checkOutput("t7_no_commit_b", 512'(bvalid), 512'(0));
    checkOutput("t7_wready_held", 512'(wready), 512'(0));
    tick();
    checkOutput("t7_no_commit_b2", 512'(bvalid), 512'(0));
    checkOutput("t7_reg_q_clear",  reg_q, expected_q());
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 32'h0);
    exp_regs[4] = 32'h77;
    checkOutput("t7_bvalid", 512'(bvalid), 512'(1));
    checkOutput("t7_reg_q",  reg_q, expected_q());
    checkOutput("t7_pulse",  512'(reg_wr_pulse), 512'(16'h0010));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
